// File: rtl/in_word_fifo.sv
// Byte-to-word input feeder for the TinyComp core: packs 4 bytes
// little-endian into 32-bit words and queues them in a small FIFO.
module in_word_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          Ph0,
    input  logic          Reset,
    input  logic [7:0]    ByteIn,
    input  logic          ByteValid,
    output logic          ByteRdy,
    input  logic          Discard,
    output logic [31:0]   InData,
    output logic          InRdy,
    input  logic          InStrobe,
    output logic [AW:0]   Count,
    output logic          Underflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [1:0]    lane_q, lane_d;
    logic [23:0]   hold_q, hold_d;
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          underflow_q, underflow_d;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;

    // Pointers carry an extra wrap bit so full and empty are distinct.
    assign Count     = wptr_q - rptr_q;
    assign InRdy     = (Count != '0);
    assign InData    = InRdy ? mem[rptr_q[AW-1:0]] : 32'h0;
    assign ByteRdy   = ~((lane_q == 2'd3) && (Count == FULL_CNT));
    assign Underflow = underflow_q;

    assign accept = ByteValid & ByteRdy;
    assign push   = accept & ~Discard & (lane_q == 2'd3);
    assign pop    = InStrobe & InRdy;

    always_comb begin
        lane_d      = lane_q;
        hold_d      = hold_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        underflow_d = underflow_q | (InStrobe & ~InRdy);
        if (Discard) begin
            lane_d = 2'd0;
            hold_d = 24'h0;
        end else if (accept) begin
            lane_d = lane_q + 2'd1;
            unique case (lane_q)
                2'd0:    hold_d[7:0]   = ByteIn;
                2'd1:    hold_d[15:8]  = ByteIn;
                2'd2:    hold_d[23:16] = ByteIn;
                default: wptr_d        = wptr_q + 1'b1;
            endcase
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge Ph0 or negedge Reset) begin
        if (!Reset) begin
            lane_q      <= 2'd0;
            hold_q      <= 24'h0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            hold_q      <= hold_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; InData is gated while empty.
    always_ff @(posedge Ph0) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= {ByteIn, hold_q};
        end
    end

endmodule
